instr_fetch_queue: RTL and testbench

Front-end producer for dispatch_unit. Owns the fetch PC, issues sequential word reads to the instruction memory, and buffers returned instructions with their PCs in a small FIFO. Presents the FIFO head to dispatch on the ifq_* interface and pops on dispatch_rd. On jump_branch_valid it flushes all buffered and in-flight fetches and redirects the PC.

---
 rtl/instr_fetch_queue_if.sv | 24 ++
 rtl/instr_fetch_queue.sv | 120 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory read port, FIFO head to dispatch, and redirect input.
// The master modport is the fetch queue side; slave is the memory/dispatch side.
interface instr_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] ifq_icode;
  logic [31:0] ifq_pc;
  logic        ifq_empty;
  logic        dispatch_rd;
  logic [31:0] jump_branch_add;
  logic        jump_branch_valid;

  modport master (
    output imem_req, imem_addr, ifq_icode, ifq_pc, ifq_empty,
    input  imem_rdata, imem_rvalid, dispatch_rd, jump_branch_add, jump_branch_valid
  );

  modport slave (
    input  imem_req, imem_addr, ifq_icode, ifq_pc, ifq_empty,
    output imem_rdata, imem_rvalid, dispatch_rd, jump_branch_add, jump_branch_valid
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues sequential word reads and buffers
// {icode, pc} pairs for dispatch. Define IFQ_PERF_CNT_EN to add fetch/flush counters.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_queue_if.master bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushes
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthOcc = DEPTH[CntW:0];

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic            inflight_q, inflight_d;
  logic            squash_q, squash_d;

  logic [31:0]     icode_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];

  logic [CntW:0]   occupancy;
  logic            flush, req, push, pop, empty;

  // Target alignment drops the byte offset.
  logic unused_jb_lsbs;
  assign unused_jb_lsbs = ^bus.jump_branch_add[1:0];

  always_comb begin
    flush     = bus.jump_branch_valid;
    // Credit check counts the outstanding read but never a same-cycle pop.
    occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    req       = rst && (occupancy < DepthOcc) && !flush;
    push      = bus.imem_rvalid && inflight_q && !squash_q && !flush;
    pop       = bus.dispatch_rd && (count_q != '0) && !flush;

    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = req;
    squash_d   = 1'b0;
    req_pc_d   = req ? fetch_pc_q : req_pc_q;

    if (flush) begin
      fetch_pc_d = {bus.jump_branch_add[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      squash_d   = inflight_q;
    end else begin
      if (req)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) wr_ptr_d   = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d   = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  // Storage needs no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      icode_mem[wr_ptr_q] <= bus.imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign empty         = (count_q == '0);
  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.ifq_empty = empty;
  assign bus.ifq_icode = empty ? 32'h0 : icode_mem[rd_ptr_q];
  assign bus.ifq_pc    = empty ? 32'h0 : pc_mem[rd_ptr_q];

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      perf_fetched <= perf_fetched + {31'd0, push};
      perf_flushes <= perf_flushes + {31'd0, flush};
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory responder, in-order PC scoreboard,
// reset/fill/drain/flush/back-to-back-flush/mid-stream-reset scenarios.
module tb_instr_fetch_queue;
  localparam logic [31:0] RstPc = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst;
  instr_fetch_queue_if bus();

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (RstPc)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushes (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_reqs   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_empty;
  logic [31:0] s_icode;
  logic [31:0] s_pc;

  function automatic logic [31:0] icode_of(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h0140_0213;
      32'h0040_0004: return 32'h01e0_0293;
      32'h0040_0008: return 32'h03c0_0313;
      default:       return a ^ 32'h5a5a_0013;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Program-order reference: the PCs dispatch should see after a (re)start at base.
  task automatic expect_stream(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // One clock: sample mid-cycle, score any pop, then answer last cycle's request.
  task automatic step();
    #3;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_empty = bus.ifq_empty;
    s_icode = bus.ifq_icode;
    s_pc    = bus.ifq_pc;
    if (s_req) n_reqs++;
    if (rst && bus.dispatch_rd && !bus.jump_branch_valid && !s_empty) begin
      n_pops++;
      chk("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        chk("sb_pc", s_pc, exp_pc);
        chk("sb_icode", s_icode, icode_of(exp_pc));
      end
    end
    @(posedge clk);
    #1;
    bus.imem_rvalid = s_req;
    bus.imem_rdata  = s_req ? icode_of(s_addr) : 32'h0;
  endtask

  initial begin
    rst                   = 1'b1;
    bus.imem_rvalid       = 1'b0;
    bus.imem_rdata        = 32'h0;
    bus.dispatch_rd       = 1'b0;
    bus.jump_branch_add   = 32'h0;
    bus.jump_branch_valid = 1'b0;
    #1 rst = 1'b0;

    step();
    chk("rst_req", {31'd0, s_req}, 32'd0);
    chk("rst_empty", {31'd0, s_empty}, 32'd1);
    chk("rst_icode", s_icode, 32'h0);
    chk("rst_pc", s_pc, 32'h0);

    // Fill from reset with dispatch idle.
    rst    = 1'b1;
    n_reqs = 0;
    expect_stream(RstPc);
    step();
    chk("first_req", {31'd0, s_req}, 32'd1);
    chk("first_addr", s_addr, RstPc);
    chk("empty_c0", {31'd0, s_empty}, 32'd1);
    step();
    chk("empty_c1", {31'd0, s_empty}, 32'd1);
    step();
    chk("empty_c2", {31'd0, s_empty}, 32'd0);
    chk("head_pc", s_pc, 32'h0040_0000);
    chk("head_icode", s_icode, 32'h0140_0213);
    repeat (5) step();
    chk("req_total", n_reqs, 32'd4);
    chk("req_held_off", {31'd0, s_req}, 32'd0);

    // Drain a full FIFO while fetch keeps up.
    bus.dispatch_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_gap", {31'd0, s_empty}, 32'd0);
    end
    chk("pops_8", n_pops, 32'd8);

    // Build 3 entries + 1 in flight, then redirect.
    bus.dispatch_rd = 1'b0;
    step();
    bus.jump_branch_valid = 1'b1;
    bus.jump_branch_add   = 32'h0040_0100;
    step();
    chk("flush_no_req", {31'd0, s_req}, 32'd0);
    bus.jump_branch_valid = 1'b0;
    expect_stream(32'h0040_0100);
    bus.dispatch_rd = 1'b1;  // pops on empty must be ignored
    step();
    chk("flush_empty", {31'd0, s_empty}, 32'd1);
    chk("empty_icode", s_icode, 32'h0);
    chk("empty_pc", s_pc, 32'h0);
    chk("target_req", {31'd0, s_req}, 32'd1);
    chk("target_addr", s_addr, 32'h0040_0100);
    step();
    chk("target_empty2", {31'd0, s_empty}, 32'd1);
    chk("empty_icode2", s_icode, 32'h0);
    repeat (4) step();
    chk("pops_12", n_pops, 32'd12);

    // Flush coincident with pop and return, then a second flush the next cycle.
    bus.jump_branch_valid = 1'b1;
    bus.jump_branch_add   = 32'h0000_0100;
    step();
    chk("coinc_no_req", {31'd0, s_req}, 32'd0);
    bus.jump_branch_add = 32'h0000_0203;  // low bits must be dropped
    step();
    chk("b2b_empty", {31'd0, s_empty}, 32'd1);
    chk("b2b_no_req", {31'd0, s_req}, 32'd0);
    bus.jump_branch_valid = 1'b0;
    expect_stream(32'h0000_0200);
    step();
    chk("b2b_req", {31'd0, s_req}, 32'd1);
    chk("b2b_addr", s_addr, 32'h0000_0200);
    chk("b2b_empty2", {31'd0, s_empty}, 32'd1);
    repeat (5) step();
    chk("pops_16", n_pops, 32'd16);

    // Reach count=3 with one in flight, then assert reset asynchronously.
    bus.dispatch_rd = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("mid_rst_empty", {31'd0, s_empty}, 32'd1);
    chk("mid_rst_req", {31'd0, s_req}, 32'd0);
    chk("mid_rst_icode", s_icode, 32'h0);
    step();
    rst = 1'b1;
    expect_stream(RstPc);
    bus.dispatch_rd = 1'b1;
    step();
    chk("rerst_req", {31'd0, s_req}, 32'd1);
    chk("rerst_addr", s_addr, RstPc);
    repeat (5) step();
    chk("pops_20", n_pops, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
